// File: rtl/bnn_pkg.sv
// Shared types and helpers for the binary-neural-network layer sequencer.
package bnn_pkg;

  localparam int unsigned DEF_NEURONS = 4;
  localparam int unsigned DEF_ACT_W   = 8;
  localparam int unsigned DEF_THR_W   = 4;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    IDLE    = 2'd1,
    COMPUTE = 2'd2,
    OUT     = 2'd3
  } state_t;

  // Number of set bits in a word of up to 32 bits.
  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + 32'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/bnn_xnor_pop.sv
// Single XNOR-popcount neuron: fires when the number of matching bits reaches thr.
module bnn_xnor_pop
  import bnn_pkg::*;
#(
  parameter int unsigned ACT_W = DEF_ACT_W,
  parameter int unsigned THR_W = DEF_THR_W
) (
  input  logic [ACT_W-1:0] act,
  input  logic [ACT_W-1:0] weight,
  input  logic [THR_W-1:0] thr,
  output logic             fire_c
);

  logic [ACT_W-1:0] agree;

  always_comb begin
    agree  = ~(act ^ weight);
    fire_c = popcount(32'(agree)) >= 32'(thr);
  end

endmodule

// File: rtl/bnn_layer_seq.sv
// Layer sequencer: loads per-neuron weights, then runs one shared neuron
// datapath over all neurons for each activation and returns the packed result.
module bnn_layer_seq
  import bnn_pkg::*;
#(
  parameter int unsigned NEURONS = DEF_NEURONS,
  parameter int unsigned ACT_W   = DEF_ACT_W,
  parameter int unsigned THR_W   = DEF_THR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  input  logic [ACT_W-1:0]   cfg_data,
  output logic               cfg_ready,
  input  logic               cfg_clear,
  input  logic               act_valid,
  input  logic [ACT_W-1:0]   act_data,
  input  logic [THR_W-1:0]   act_thr,
  output logic               act_ready,
  output logic               res_valid,
  output logic [NEURONS-1:0] res_data,
  input  logic               res_ready,
  output logic               busy
);

  localparam int unsigned     IDX_W = (NEURONS > 1) ? $clog2(NEURONS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NEURONS - 1);

  state_t           state;
  state_t           state_n;
  logic [IDX_W-1:0] wcnt;
  logic [IDX_W-1:0] idx;
  logic [ACT_W-1:0] weight [NEURONS];
  logic [ACT_W-1:0] act_q;
  logic [THR_W-1:0] thr_q;
  logic             cfg_hs;
  logic             act_hs;
  logic             res_hs;
  logic             fire_c;

  bnn_xnor_pop #(
    .ACT_W (ACT_W),
    .THR_W (THR_W)
  ) u_neuron (
    .act    (act_q),
    .weight (weight[idx]),
    .thr    (thr_q),
    .fire_c (fire_c)
  );

  // Next-state decode; a clear in LOAD drops any byte offered in the same cycle.
  always_comb begin
    state_n = state;
    cfg_hs  = cfg_valid & cfg_ready & ~cfg_clear;
    act_hs  = act_valid & act_ready;
    res_hs  = res_valid & res_ready;
    case (state)
      LOAD:    if (cfg_hs && wcnt == LAST) state_n = IDLE;
      IDLE: begin
        if (act_hs)         state_n = COMPUTE;
        else if (cfg_clear) state_n = LOAD;
      end
      COMPUTE: if (idx == LAST) state_n = OUT;
      OUT:     if (res_hs) state_n = IDLE;
      default: state_n = LOAD;
    endcase
  end

  // State register; handshake flags are registered copies of the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      cfg_ready <= 1'b1;
      act_ready <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cfg_ready <= (state_n == LOAD);
      act_ready <= (state_n == IDLE);
      res_valid <= (state_n == OUT);
      busy      <= (state_n == COMPUTE);
    end
  end

  // Weight file, counters and result accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt     <= '0;
      idx      <= '0;
      act_q    <= '0;
      thr_q    <= '0;
      res_data <= '0;
      for (int n = 0; n < int'(NEURONS); n++) begin
        weight[n] <= '0;
      end
    end else begin
      case (state)
        LOAD: begin
          if (cfg_clear) begin
            wcnt <= '0;
          end else if (cfg_hs) begin
            weight[wcnt] <= cfg_data;
            wcnt         <= (wcnt == LAST) ? '0 : wcnt + IDX_W'(1);
          end
        end
        IDLE: begin
          if (act_hs) begin
            act_q    <= act_data;
            thr_q    <= act_thr;
            idx      <= '0;
            res_data <= '0;
          end else if (cfg_clear) begin
            wcnt <= '0;
          end
        end
        COMPUTE: begin
          res_data[idx] <= fire_c;
          idx           <= idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_layer_seq.sv
// Directed bench for bnn_layer_seq with a popcount reference model of the layer.
module tb_bnn_layer_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_valid;
  logic [7:0] cfg_data;
  logic       cfg_ready;
  logic       cfg_clear;
  logic       act_valid;
  logic [7:0] act_data;
  logic [3:0] act_thr;
  logic       act_ready;
  logic       res_valid;
  logic [3:0] res_data;
  logic       res_ready;
  logic       busy;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] tw [4];
  logic [3:0] exp_res;
  bit         exp_valid = 1'b0;

  always #5 clk = ~clk;

  bnn_layer_seq #(.NEURONS(4), .ACT_W(8), .THR_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .cfg_clear (cfg_clear),
    .act_valid (act_valid),
    .act_data  (act_data),
    .act_thr   (act_thr),
    .act_ready (act_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_ready (res_ready),
    .busy      (busy)
  );

  // Reference: neuron n fires when the count of bits where act equals weight reaches thr.
  function automatic logic [3:0] model(input logic [7:0] a, input logic [3:0] t);
    logic [3:0] r;
    logic [7:0] x;
    for (int n = 0; n < 4; n++) begin
      x    = ~(a ^ tw[n]);
      r[n] = ($countones(x) >= int'(t));
    end
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
    end
  endtask

  // Every-cycle checks: handshake flags mutually exclusive, result matches the model.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      logic [1:0] s;
      s = 2'(cfg_ready) + 2'(act_ready) + 2'(res_valid);
      check("ready_excl", 32'(s > 2'd1), 32'd0);
      if (res_valid && exp_valid) check("model_res", 32'(res_data), 32'(exp_res));
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
    check({tag, "_act_ready"}, 32'(act_ready), 32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_res_data"},  32'(res_data),  32'd0);
  endtask

  task automatic load_weights(input logic [31:0] ws);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("load_cfg_ready", 32'(cfg_ready), 32'd1);
      cfg_valid = 1'b1;
      cfg_data  = ws[8*i +: 8];
      tw[i]     = ws[8*i +: 8];
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    check("load_done_cfg_ready", 32'(cfg_ready), 32'd0);
    check("load_done_act_ready", 32'(act_ready), 32'd1);
  endtask

  task automatic run(input logic [7:0] a, input logic [3:0] t, input logic [3:0] want,
                     input int hold, input int clr_at);
    int k;
    k = 0;
    @(negedge clk);
    while (!act_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("act_ready_wait", 32'(act_ready), 32'd1);
    act_valid = 1'b1;
    act_data  = a;
    act_thr   = t;
    res_ready = (hold == 0);
    exp_res   = model(a, t);
    exp_valid = 1'b1;
    check("model_pin", 32'(exp_res), 32'(want));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      act_valid = 1'b0;
      cfg_clear = (c == clr_at);
      check("compute_busy",      32'(busy),      32'd1);
      check("compute_res_valid", 32'(res_valid), 32'd0);
      check("compute_act_ready", 32'(act_ready), 32'd0);
    end
    @(negedge clk);
    cfg_clear = 1'b0;
    check("out_busy",      32'(busy),      32'd0);
    check("out_res_valid", 32'(res_valid), 32'd1);
    check("out_res_data",  32'(res_data),  32'(want));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_res_valid", 32'(res_valid), 32'd1);
      check("hold_res_data",  32'(res_data),  32'(want));
      check("hold_act_ready", 32'(act_ready), 32'd0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("after_res_valid", 32'(res_valid), 32'd0);
    check("after_act_ready", 32'(act_ready), 32'd1);
    check("after_res_data",  32'(res_data),  32'(want));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_data = '0; cfg_clear = 1'b0;
    act_valid = 1'b0; act_data = '0; act_thr = '0; res_ready = 1'b0;
    for (int i = 0; i < 4; i++) tw[i] = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Weight load FF,00,F0,AA; then a fifth byte must be refused.
    load_weights(32'hAAF0_00FF);
    cfg_valid = 1'b1;
    cfg_data  = 8'h55;
    repeat (3) begin
      @(negedge clk);
      check("extra_byte_cfg_ready", 32'(cfg_ready), 32'd0);
    end
    cfg_valid = 1'b0;

    // Main inference, threshold variants, backpressure and threshold bounds.
    run(8'hF0, 4'd5, 4'b0100, 0, -1);
    run(8'hF0, 4'd4, 4'b1111, 0, -1);
    run(8'hF0, 4'd5, 4'b0100, 10, -1);
    run(8'h3C, 4'd0, 4'hF, 0, -1);
    run(8'h5A, 4'd9, 4'h0, 0, -1);

    // Clear during COMPUTE is ignored.
    run(8'hF0, 4'd5, 4'b0100, 0, 1);

    // Clear in IDLE returns to LOAD; a clear colliding with a byte drops that byte.
    @(negedge clk);
    cfg_clear = 1'b1;
    @(negedge clk);
    cfg_clear = 1'b0;
    check("clear_cfg_ready", 32'(cfg_ready), 32'd1);
    check("clear_act_ready", 32'(act_ready), 32'd0);
    cfg_valid = 1'b1;
    cfg_data  = 8'h11;
    tw[0]     = 8'h11;
    @(negedge clk);
    cfg_data  = 8'h22;
    cfg_clear = 1'b1;
    @(negedge clk);
    cfg_clear = 1'b0;
    cfg_valid = 1'b0;
    check("clear_load_cfg_ready", 32'(cfg_ready), 32'd1);
    load_weights(32'h0000_0000);
    run(8'h00, 4'd8, 4'hF, 0, -1);

    // Reset in the second COMPUTE cycle, then reload and rerun.
    @(negedge clk);
    check("pre_rst_act_ready", 32'(act_ready), 32'd1);
    act_valid = 1'b1;
    act_data  = 8'hF0;
    act_thr   = 4'd5;
    @(negedge clk);
    act_valid = 1'b0;
    check("pre_rst_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst_n     = 1'b0;
    exp_valid = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    load_weights(32'hAAF0_00FF);
    run(8'hF0, 4'd5, 4'b0100, 0, -1);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
